// File: rtl/iz_neuron_core.sv
// Izhikevich neuron integrator: advances (v,u) by one 1 ms step per request,
// sharing a single 16x16 signed multiplier over a four-cycle sequence.
module iz_neuron_core #(
  parameter logic signed [15:0] V_INIT = -16'sd1040,
  parameter logic signed [15:0] U_INIT = -16'sd208,
  parameter logic signed [15:0] V_TH   = 16'sd480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               step_en,
  input  logic               params_ready,
  input  logic signed [11:0] param_a,
  input  logic signed [11:0] param_b,
  input  logic signed [11:0] param_c,
  input  logic signed [11:0] param_d,
  input  logic signed [11:0] current_in,
  output logic signed [15:0] v_out,
  output logic signed [15:0] u_out,
  output logic               spike,
  output logic               step_done,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, CALC_VV, CALC_BV, CALC_AU, UPDATE} state_t;

  localparam logic signed [39:0] V_TH_X   = 40'(V_TH);
  localparam logic signed [39:0] V_OFFSET = 40'sd2240;

  function automatic logic signed [15:0] sat16(input logic signed [39:0] x);
    if (x > 40'sd32767)       return 16'sd32767;
    else if (x < -40'sd32768) return -16'sd32768;
    else                      return x[15:0];
  endfunction

  function automatic logic signed [39:0] sx16(input logic signed [15:0] x);
    return 40'(x);
  endfunction

  function automatic logic signed [39:0] sx12(input logic signed [11:0] x);
    return 40'(x);
  endfunction

  function automatic logic signed [39:0] sx32(input logic signed [31:0] x);
    return 40'(x);
  endfunction

  function automatic logic signed [15:0] sx12_16(input logic signed [11:0] x);
    return 16'(x);
  endfunction

  state_t state_q, state_d;
  logic signed [15:0] v_q, v_d, u_q, u_d;
  logic signed [31:0] p_vv_q, p_vv_d, p_bv_q, p_bv_d, p_au_q, p_au_d;
  logic spike_q, spike_d, step_done_q, step_done_d, busy_q, busy_d;
  logic pr_q, pr_d;

  logic signed [15:0] mul_x, mul_y;
  logic signed [31:0] mul_p;
  logic signed [39:0] v_x, u_x, p_vv_x, sq, bv, diff, du, vn, un;
  logic signed [15:0] un_sat, u_spk;

  // Shared multiplier operand selection and update arithmetic
  always_comb begin
    v_x    = sx16(v_q);
    u_x    = sx16(u_q);
    p_vv_x = sx32(p_vv_q);
    // 0.04 * v^2 in Q4: (v^2 * 41) >> 14, 41 = 32 + 8 + 1
    sq     = ((p_vv_x <<< 5) + (p_vv_x <<< 3) + p_vv_x) >>> 14;
    bv     = sx32(p_bv_q) >>> 8;
    diff   = bv - u_x;
    du     = sx32(p_au_q) >>> 8;
    vn     = v_x + sq + (v_x <<< 2) + v_x + V_OFFSET - u_x + sx12(current_in);
    un     = u_x + du;
    un_sat = sat16(un);
    u_spk  = sat16(sx16(un_sat) + (sx12(param_d) >>> 4));
    mul_x  = v_q;
    mul_y  = v_q;
    case (state_q)
      CALC_BV: mul_x = sx12_16(param_b);
      CALC_AU: begin
        mul_x = sx12_16(param_a);
        // (bv - u) is clamped to the 16-bit multiplier operand range
        mul_y = sat16(diff);
      end
      default: ;
    endcase
    mul_p = mul_x * mul_y;
  end

  // Next-state and register update logic
  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    u_d         = u_q;
    p_vv_d      = p_vv_q;
    p_bv_d      = p_bv_q;
    p_au_d      = p_au_q;
    spike_d     = 1'b0;
    step_done_d = 1'b0;
    busy_d      = (state_q != IDLE);
    pr_d        = params_ready;
    if (state_q != IDLE && !params_ready) begin
      // Parameters withdrawn mid-step: drop the step, keep v/u
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (params_ready && !pr_q) begin
            v_d = sx12_16(param_c);
            u_d = 16'sd0;
          end else if (step_en && params_ready) begin
            state_d = CALC_VV;
          end
        end
        CALC_VV: begin
          p_vv_d  = mul_p;
          state_d = CALC_BV;
        end
        CALC_BV: begin
          p_bv_d  = mul_p;
          state_d = CALC_AU;
        end
        CALC_AU: begin
          p_au_d  = mul_p;
          state_d = UPDATE;
        end
        UPDATE: begin
          state_d     = IDLE;
          step_done_d = 1'b1;
          if (vn >= V_TH_X) begin
            v_d     = sx12_16(param_c);
            u_d     = u_spk;
            spike_d = 1'b1;
          end else begin
            v_d = sat16(vn);
            u_d = un_sat;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and state registers; the edge detector loads the live level in
  // reset so a params_ready already high at release is not seen as an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      v_q         <= V_INIT;
      u_q         <= U_INIT;
      spike_q     <= 1'b0;
      step_done_q <= 1'b0;
      busy_q      <= 1'b0;
      pr_q        <= params_ready;
    end else if (enable) begin
      state_q     <= state_d;
      v_q         <= v_d;
      u_q         <= u_d;
      spike_q     <= spike_d;
      step_done_q <= step_done_d;
      busy_q      <= busy_d;
      pr_q        <= pr_d;
    end
  end

  // Product registers, written only in their own sequence state
  always_ff @(posedge clk) begin
    if (enable) begin
      p_vv_q <= p_vv_d;
      p_bv_q <= p_bv_d;
      p_au_q <= p_au_d;
    end
  end

  assign v_out     = v_q;
  assign u_out     = u_q;
  assign spike     = spike_q;
  assign step_done = step_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_iz_neuron_core.sv
// Directed bench for iz_neuron_core.
module tb_iz_neuron_core;

  logic clk = 1'b0;
  logic reset, enable, step_en, params_ready;
  logic signed [11:0] param_a, param_b, param_c, param_d, current_in;
  logic signed [15:0] v_out, u_out;
  logic spike, step_done, busy;

  int checks = 0;
  int errors = 0;

  iz_neuron_core dut (
    .clk(clk), .reset(reset), .enable(enable), .step_en(step_en),
    .params_ready(params_ready), .param_a(param_a), .param_b(param_b),
    .param_c(param_c), .param_d(param_d), .current_in(current_in),
    .v_out(v_out), .u_out(u_out), .spike(spike), .step_done(step_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_step(input int v, input int u, input int a, input int b,
                            input int c, input int d, input int i,
                            output int nv, output int nu, output int spk);
    longint sq, bv, df, du, vn, un;
    sq = (longint'(v) * v * 41) >>> 14;
    bv = (longint'(b) * v) >>> 8;
    df = sat(bv - u);
    du = (longint'(a) * df) >>> 8;
    vn = longint'(v) + sq + 5 * longint'(v) + 2240 - u + i;
    un = sat(longint'(u) + du);
    if (vn >= 480) begin
      nv = c; nu = int'(sat(un + (d >>> 4))); spk = 1;
    end else begin
      nv = int'(sat(vn)); nu = int'(un); spk = 0;
    end
  endtask

  // Request one step, wait (bounded) for step_done; returns ticks taken
  task automatic do_step(output int lat);
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (step_done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, mv, mu, nv, nu, spk, spikes, first_spike;
    reset = 1'b1; enable = 1'b1; step_en = 1'b0; params_ready = 1'b1;
    param_a = 12'sd51; param_b = 12'sd51; param_c = -12'sd1040;
    param_d = 12'sd512; current_in = 12'sd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_v", v_out, -1040);
    chk("rst_u", u_out, -208);
    chk("rst_busy", busy, 0);
    chk("rst_spike", spike, 0);
    chk("rst_done", step_done, 0);

    // One step with timing of busy/step_done
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
    chk("n0_busy", busy, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("mid_busy", busy, 1);
      chk("mid_done", step_done, 0);
    end
    tick();
    chk("n4_busy", busy, 1);
    chk("n4_done", step_done, 1);
    chk("n4_spike", spike, 0);
    chk("step1_v", v_out, -1086);
    chk("step1_u", u_out, -208);
    tick();
    chk("n5_busy", busy, 0);
    chk("n5_done", step_done, 0);

    // Freeze with enable low keeps pulses and state
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
    tick(); tick(); tick();
    enable = 1'b0;
    tick(); tick();
    chk("frz_done", step_done, 0);
    chk("frz_busy", busy, 1);
    enable = 1'b1;
    tick();
    chk("frz_done2", step_done, 1);
    tick();
    mv = v_out; mu = u_out;

    // step_en without params_ready is ignored
    params_ready = 1'b0;
    step_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("nopr_busy", busy, 0);
      chk("nopr_done", step_done, 0);
    end
    chk("nopr_v", v_out, mv);
    chk("nopr_u", u_out, mu);

    // Rising params_ready re-inits and beats step_en
    param_c = -12'sd1280;
    params_ready = 1'b1;
    tick();
    step_en = 1'b0;
    chk("reinit_v", v_out, -1280);
    chk("reinit_u", u_out, 0);
    tick();
    chk("reinit_nostep", busy, 0);

    // Abort during CALC_BV
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
    tick();
    params_ready = 1'b0;
    tick();
    tick();
    chk("abort_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      chk("abort_done", step_done, 0);
      tick();
    end
    chk("abort_v", v_out, -1280);
    chk("abort_u", u_out, 0);
    params_ready = 1'b1;
    tick();

    // Reset during CALC_AU
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_v", v_out, -1040);
    chk("mrst_u", u_out, -208);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", step_done, 0);
    tick(); tick(); tick(); tick();
    chk("mrst_nodone", step_done, 0);
    chk("mrst_v2", v_out, -1040);

    // Strong drive: repeated spikes, saturation rather than wrap
    current_in = 12'sd2047;
    param_c = -12'sd1280;
    mv = -1040; mu = -208;
    spikes = 0; first_spike = 1;
    for (int s = 0; s < 25; s++) begin
      model_step(mv, mu, 51, 51, -1280, 512, 2047, nv, nu, spk);
      do_step(lat);
      chk("drv_lat", lat, 4);
      chk("drv_v", v_out, nv);
      chk("drv_u", u_out, nu);
      chk("drv_spike", spike, spk);
      if (spk != 0) begin
        spikes++;
        if (first_spike != 0) begin
          first_spike = 0;
          chk("spk_v", v_out, -1280);
          chk("spk_u", u_out, -176);
        end
      end
      mv = nv; mu = nu;
      tick();
    end
    chk("spikes_seen", (spikes > 0) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
